pq_shift_sorter: RTL and testbench

- Parametrised register-array (shift-register) hardware priority queue of <key,value> pairs. Holds entries sorted by priority and presents the highest-priority entry at its head every cycle.
- Supports single-cycle enqueue, dequeue and combined replace; selectable min-first or max-first ordering.
- FIFO tie-breaking among equal keys; per-slot valid bits, so every key value (including all-ones and all-zeros) is a legal priority.
- Serves as a baseline HWPQ implementation behind the team's standard queue interface.

---
 rtl/pq_pkg.sv | 39 +++
 rtl/pq_cell.sv | 93 +++++++++
 rtl/pq_shift_sorter.sv | 104 ++++++++++
 tb/tb_pq_shift_sorter.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/pq_pkg.sv
// Shared types, reset constants and the ordering predicate for the shift-register priority queue.
// Key constants are declared at maximum width and sliced down by each user.
package pq_pkg;

    localparam int PQ_KEY_MAX_W = 64;
    localparam int PQ_VAL_MAX_W = 64;

    typedef logic [PQ_KEY_MAX_W-1:0] pq_key_t;
    typedef logic [PQ_VAL_MAX_W-1:0] pq_val_t;

    // Widest pair; the design narrows it with its own KEY_WIDTH/VAL_WIDTH struct.
    typedef struct packed {
        pq_key_t key;
        pq_val_t val;
    } pq_kv_max_t;

    localparam pq_key_t KEYINF = '1;
    localparam pq_key_t KEY0   = '0;
    localparam pq_val_t VAL0   = '0;

    typedef enum logic [1:0] {
        OP_IDLE,
        OP_ENQ,
        OP_DEQ,
        OP_REPL
    } pq_op_e;

    // Strict comparison so equal keys keep arrival order; an empty slot loses to anything.
    function automatic logic beats(input pq_key_t new_key,
                                   input pq_key_t slot_key,
                                   input logic    slot_vld,
                                   input logic    max_first);
        if (!slot_vld) begin
            return 1'b1;
        end
        return max_first ? (new_key > slot_key) : (new_key < slot_key);
    endfunction

endpackage

// File: rtl/pq_cell.sv
// One priority-queue slot: valid + kv registers and the insert/shift/replace next-state mux.
// Single-cycle update; no backpressure of its own, the top only issues legal ops.
module pq_cell
    import pq_pkg::*;
#(
    parameter int KEY_WIDTH = 8,
    parameter int VAL_WIDTH = 8,
    parameter int MAX_FIRST = 0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  pq_op_e                         op_i,
    input  logic                           head_i,
    input  logic [KEY_WIDTH+VAL_WIDTH-1:0] kvi_i,
    input  logic                           left_vld_i,
    input  logic [KEY_WIDTH+VAL_WIDTH-1:0] left_kv_i,
    input  logic                           right_vld_i,
    input  logic [KEY_WIDTH+VAL_WIDTH-1:0] right_kv_i,
    output logic                           vld_o,
    output logic [KEY_WIDTH+VAL_WIDTH-1:0] kv_o
);

    typedef struct packed {
        logic [KEY_WIDTH-1:0] key;
        logic [VAL_WIDTH-1:0] val;
    } kv_t;

    localparam logic MF = (MAX_FIRST != 0);
    localparam kv_t  RST_KV = '{
        key: MF ? KEY0[KEY_WIDTH-1:0] : KEYINF[KEY_WIDTH-1:0],
        val: VAL0[VAL_WIDTH-1:0]
    };

    kv_t  kvi, left_kv, right_kv;
    kv_t  kv_q, kv_d;
    logic vld_q, vld_d;
    logic b_self, b_left, b_right;

    assign kvi      = kv_t'(kvi_i);
    assign left_kv  = kv_t'(left_kv_i);
    assign right_kv = kv_t'(right_kv_i);

    assign b_self  = beats(pq_key_t'(kvi.key), pq_key_t'(kv_q.key), vld_q, MF);
    assign b_left  = beats(pq_key_t'(kvi.key), pq_key_t'(left_kv.key), left_vld_i, MF);
    assign b_right = beats(pq_key_t'(kvi.key), pq_key_t'(right_kv.key), right_vld_i, MF);

    always_comb begin
        vld_d = vld_q;
        kv_d  = kv_q;
        unique case (op_i)
            OP_ENQ: begin
                if (b_self) begin
                    if (head_i || !b_left) begin
                        vld_d = 1'b1;
                        kv_d  = kvi;
                    end else begin
                        vld_d = left_vld_i;
                        kv_d  = left_kv;
                    end
                end
            end
            OP_DEQ: begin
                vld_d = right_vld_i;
                kv_d  = right_kv;
            end
            // Replace = remove head, then insert: the new entry lands where the shifted run stops.
            OP_REPL: begin
                if (!b_right) begin
                    vld_d = right_vld_i;
                    kv_d  = right_kv;
                end else if (head_i || !b_self) begin
                    vld_d = 1'b1;
                    kv_d  = kvi;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
            kv_q  <= RST_KV;
        end else begin
            vld_q <= vld_d;
            kv_q  <= kv_d;
        end
    end

    assign vld_o = vld_q;
    assign kv_o  = kv_q;

endmodule

// File: rtl/pq_shift_sorter.sv
// Register-array priority queue: sorted slots, head at slot 0, enqueue/dequeue/replace per cycle.
// One-cycle latency, no bubbles; enq when full / deq when empty are dropped and flagged by ovf/unf.
module pq_shift_sorter
    import pq_pkg::*;
#(
    parameter int KEY_WIDTH = 8,
    parameter int VAL_WIDTH = 8,
    parameter int CAPACITY  = 15,
    parameter int MAX_FIRST = 0,
    parameter int CNT_W     = $clog2(CAPACITY + 1)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           enq,
    input  logic                           deq,
    input  logic [KEY_WIDTH+VAL_WIDTH-1:0] kvi,
    output logic [KEY_WIDTH+VAL_WIDTH-1:0] kvo,
    output logic                           kvo_valid,
    output logic                           full,
    output logic                           empty,
    output logic [CNT_W-1:0]               count,
    output logic                           ovf,
    output logic                           unf
);

    localparam int KV_W = KEY_WIDTH + VAL_WIDTH;

    // Slot i lives at chain index i+1; indices 0 and CAPACITY+1 are permanently empty borders.
    logic [CAPACITY+1:0] chain_vld;
    logic [KV_W-1:0]     chain_kv [CAPACITY+2];

    pq_op_e          op;
    logic [CNT_W-1:0] count_q, count_d;
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;

    assign full  = (count_q == CNT_W'(CAPACITY));
    assign empty = (count_q == '0);

    always_comb begin
        op = OP_IDLE;
        unique case ({enq, deq})
            2'b10:   if (!full)  op = OP_ENQ;
            2'b01:   if (!empty) op = OP_DEQ;
            2'b11:   op = empty ? OP_ENQ : OP_REPL;
            default: op = OP_IDLE;
        endcase
    end

    always_comb begin
        count_d = count_q;
        unique case (op)
            OP_ENQ:  count_d = count_q + CNT_W'(1);
            OP_DEQ:  count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        ovf_d = enq && !deq && full;
        unf_d = deq && empty;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign chain_vld[0]            = 1'b0;
    assign chain_kv[0]             = '0;
    assign chain_vld[CAPACITY+1]   = 1'b0;
    assign chain_kv[CAPACITY+1]    = '0;

    for (genvar i = 0; i < CAPACITY; i++) begin : g_slot
        pq_cell #(
            .KEY_WIDTH (KEY_WIDTH),
            .VAL_WIDTH (VAL_WIDTH),
            .MAX_FIRST (MAX_FIRST)
        ) u_cell (
            .clk         (clk),
            .rst_n       (rst_n),
            .op_i        (op),
            .head_i      (i == 0),
            .kvi_i       (kvi),
            .left_vld_i  (chain_vld[i]),
            .left_kv_i   (chain_kv[i]),
            .right_vld_i (chain_vld[i+2]),
            .right_kv_i  (chain_kv[i+2]),
            .vld_o       (chain_vld[i+1]),
            .kv_o        (chain_kv[i+1])
        );
    end

    assign kvo       = chain_kv[1];
    assign kvo_valid = chain_vld[1];
    assign count     = count_q;
    assign ovf       = ovf_q;
    assign unf       = unf_q;

endmodule

// File: tb/tb_pq_shift_sorter.sv
// Scoreboarded bench: a sorted-list reference model supplies expected heads, counts and pulses.
module tb_pq_shift_sorter;

    localparam int CAP = 15;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        enq, deq;
    logic [15:0] kvi, kvo;
    logic        kvo_valid, full, empty, ovf, unf;
    logic [3:0]  count;

    logic        m_enq, m_deq;
    logic [15:0] m_kvi, m_kvo;
    logic        m_kvo_valid, m_full, m_empty, m_ovf, m_unf;
    logic [3:0]  m_count;

    int errors = 0;
    int checks = 0;
    int vseq   = 0;

    logic [15:0] mdl [$];
    logic [15:0] sb_q [$];

    pq_shift_sorter #(.KEY_WIDTH(8), .VAL_WIDTH(8), .CAPACITY(CAP), .MAX_FIRST(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .enq(enq), .deq(deq), .kvi(kvi), .kvo(kvo),
        .kvo_valid(kvo_valid), .full(full), .empty(empty), .count(count), .ovf(ovf), .unf(unf)
    );

    pq_shift_sorter #(.KEY_WIDTH(8), .VAL_WIDTH(8), .CAPACITY(CAP), .MAX_FIRST(1)) u_max (
        .clk(clk), .rst_n(rst_n), .enq(m_enq), .deq(m_deq), .kvi(m_kvi), .kvo(m_kvo),
        .kvo_valid(m_kvo_valid), .full(m_full), .empty(m_empty), .count(m_count),
        .ovf(m_ovf), .unf(m_unf)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic void mdl_ins(input logic [15:0] kv);
        int pos = mdl.size();
        for (int i = 0; i < mdl.size(); i++) begin
            if (kv[15:8] < mdl[i][15:8]) begin
                pos = i;
                break;
            end
        end
        mdl.insert(pos, kv);
    endfunction

    task automatic check_state(input logic exp_ovf, input logic exp_unf);
        chk("count", 32'(count), 32'(mdl.size()));
        chk("empty", 32'(empty), 32'(mdl.size() == 0));
        chk("full", 32'(full), 32'(mdl.size() == CAP));
        chk("kvo_valid", 32'(kvo_valid), 32'(mdl.size() != 0));
        if (mdl.size() != 0) chk("kvo", 32'(kvo), 32'(mdl[0]));
        chk("ovf", 32'(ovf), 32'(exp_ovf));
        chk("unf", 32'(unf), 32'(exp_unf));
    endtask

    // Called at a falling edge; returns at the next falling edge, so ops run back to back.
    task automatic op(input logic e, input logic d, input logic [7:0] k, input logic [7:0] v);
        logic        exp_ovf, exp_unf;
        logic [15:0] kv;
        kv      = {k, v};
        enq     = e;
        deq     = d;
        kvi     = kv;
        exp_ovf = e && !d && (mdl.size() == CAP);
        exp_unf = d && (mdl.size() == 0);
        if (d && mdl.size() != 0) begin
            sb_q.push_back(mdl[0]);
            chk("deq_head", 32'(kvo), 32'(sb_q.pop_front()));
        end
        @(posedge clk);
        #1;
        enq = 1'b0;
        deq = 1'b0;
        if (d && mdl.size() != 0) mdl.delete(0);
        if (e && !exp_ovf) mdl_ins(kv);
        check_state(exp_ovf, exp_unf);
        @(negedge clk);
    endtask

    task automatic mop(input logic e, input logic d, input logic [7:0] k,
                       input int exp_cnt, input logic exp_vld, input logic [7:0] exp_key);
        m_enq = e;
        m_deq = d;
        m_kvi = {k, 8'h5A};
        @(posedge clk);
        #1;
        m_enq = 1'b0;
        m_deq = 1'b0;
        chk("max_count", 32'(m_count), 32'(exp_cnt));
        chk("max_kvo_valid", 32'(m_kvo_valid), 32'(exp_vld));
        if (exp_vld) chk("max_key", 32'(m_kvo[15:8]), 32'(exp_key));
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        enq = 1'b0; deq = 1'b0; kvi = '0;
        m_enq = 1'b0; m_deq = 1'b0; m_kvi = '0;
        repeat (2) @(negedge clk);
        check_state(1'b0, 1'b0);
        chk("rst_kvo", 32'(kvo), 32'h0000_FF00);
        chk("rst_max_kvo", 32'(m_kvo), 32'h0);
        chk("rst_max_empty", 32'(m_empty), 32'h1);
        rst_n = 1'b1;
        @(negedge clk);

        // Tie on key 2: value 02 must leave before value 04.
        op(1, 0, 8'd5, 8'h01);
        op(1, 0, 8'd2, 8'h02);
        op(1, 0, 8'd9, 8'h03);
        op(1, 0, 8'd2, 8'h04);
        chk("count_after_4", 32'(count), 32'd4);
        chk("tie_order", 32'(kvo), 32'h0000_0202);
        repeat (4) op(0, 1, 8'd0, 8'd0);

        for (int k = 1; k <= CAP; k++) op(1, 0, 8'(k), 8'(k + 16));
        op(1, 0, 8'd0, 8'hAA);
        chk("ovf_head", 32'(kvo[15:8]), 32'd1);
        op(0, 0, 8'd0, 8'd0);
        op(1, 1, 8'd20, 8'hBB);
        chk("repl_head", 32'(kvo[15:8]), 32'd2);
        repeat (CAP) op(0, 1, 8'd0, 8'd0);

        op(0, 1, 8'd0, 8'd0);
        op(0, 0, 8'd0, 8'd0);
        op(1, 1, 8'd7, 8'h77);

        repeat (80) begin
            op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               8'($urandom_range(0, 7)), 8'(vseq));
            vseq++;
        end
        repeat (CAP) if (mdl.size() < 6) op(1, 0, 8'($urandom_range(0, 255)), 8'hC3);
        repeat (CAP) if (mdl.size() > 6) op(0, 1, 8'd0, 8'd0);
        chk("pre_reset_count", 32'(count), 32'd6);

        // Asynchronous reset lands mid-cycle; outputs must clear before the next rising edge.
        #2;
        rst_n = 1'b0;
        #1;
        mdl.delete();
        sb_q.delete();
        check_state(1'b0, 1'b0);
        chk("async_rst_kvo", 32'(kvo), 32'h0000_FF00);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        op(1, 0, 8'd3, 8'h33);

        mop(1, 0, 8'h00, 1, 1'b1, 8'h00);
        mop(1, 0, 8'hFF, 2, 1'b1, 8'hFF);
        mop(1, 0, 8'h80, 3, 1'b1, 8'hFF);
        mop(0, 1, 8'h00, 2, 1'b1, 8'h80);
        mop(0, 1, 8'h00, 1, 1'b1, 8'h00);
        mop(0, 1, 8'h00, 0, 1'b0, 8'h00);
        chk("max_empty", 32'(m_empty), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
